// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: angle command to a framed pulse, with an
// optional per-frame slew limit. Angle and enable are taken only at frame boundaries.
module servo_pwm_gen #(
    parameter int PERIOD_CYC  = 1_000_000,
    parameter int MIN_CYC     = 25_000,
    parameter int STEP_CYC    = 555,
    parameter int MAX_ANGLE   = 180,
    parameter int MAX_STEP    = 0,
    parameter int RESET_ANGLE = 90
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iAngle,
    input  logic       iEn,
    output logic       oPwm,
    output logic       oFrame,
    output logic [7:0] oCurAngle
);

    localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int WID_W = $clog2(PERIOD_CYC + 1);
    localparam int STEP_SAT = (MAX_STEP > 255) ? 255 : MAX_STEP;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD_CYC - 1);
    localparam logic [7:0]       ANG_MAX   = 8'(MAX_ANGLE);
    localparam logic [7:0]       ANG_RST   = 8'(RESET_ANGLE);
    localparam logic [7:0]       STEP8     = 8'(STEP_SAT);
    localparam logic [8:0]       STEP9     = 9'(STEP_SAT);
    localparam logic [WID_W-1:0] WID_MIN   = WID_W'(MIN_CYC);
    localparam logic [WID_W-1:0] WID_STEP  = WID_W'(STEP_CYC);
    localparam logic [WID_W-1:0] WID_RST   =
        WID_W'(MIN_CYC + RESET_ANGLE * STEP_CYC);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [WID_W-1:0] width;
    logic [WID_W-1:0] width_calc;
    logic [WID_W-1:0] width_nx;
    logic [7:0]       cur;
    logic [7:0]       cur_slew;
    logic [7:0]       cur_nx;
    logic [7:0]       tgt;
    logic [8:0]       diff_up;
    logic [8:0]       diff_dn;
    logic             en_lat;
    logic             en_nx;
    logic             boundary;
    logic             pwm;
    logic             frame;

    // Target angle after clamping, and the slew-limited step toward it.
    always_comb begin
        tgt      = (iAngle > ANG_MAX) ? ANG_MAX : iAngle;
        diff_up  = {1'b0, tgt} - {1'b0, cur};
        diff_dn  = {1'b0, cur} - {1'b0, tgt};
        cur_slew = tgt;
        if (MAX_STEP != 0) begin
            if ((tgt > cur) && (diff_up > STEP9)) begin
                cur_slew = cur + STEP8;
            end else if ((cur > tgt) && (diff_dn > STEP9)) begin
                cur_slew = cur - STEP8;
            end
        end
    end

    // Legal parameters guarantee the product fits in WID_W bits.
    always_comb begin
        width_calc = WID_MIN + WID_W'(cur_slew) * WID_STEP;
    end

    always_comb begin
        boundary = (cnt == CNT_LAST);
        cnt_nx   = boundary ? '0 : cnt + 1'b1;
        en_nx    = boundary ? iEn : en_lat;
        cur_nx   = boundary ? cur_slew : cur;
        width_nx = boundary ? width_calc : width;
    end

    // Outputs are registered from next-state values so they line up with cnt.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt    <= CNT_LAST;
            cur    <= ANG_RST;
            en_lat <= 1'b0;
            width  <= WID_RST;
            pwm    <= 1'b0;
            frame  <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            cur    <= cur_nx;
            en_lat <= en_nx;
            width  <= width_nx;
            pwm    <= en_nx && (WID_W'(cnt_nx) < width_nx);
            frame  <= (cnt_nx == '0);
        end
    end

    assign oPwm      = pwm;
    assign oFrame    = frame;
    assign oCurAngle = cur;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: vector table plus per-frame scoreboard,
// with hand sequences for slew and mid-pulse reset.
module tb_servo_pwm_gen;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [7:0] angle_a, angle_b;
    logic       en_a, en_b;
    logic       pwm_a, pwm_b;
    logic       frame_a, frame_b;
    logic [7:0] cur_a, cur_b;

    always #5 clk = ~clk;

    servo_pwm_gen #(
        .PERIOD_CYC(1000), .MIN_CYC(50), .STEP_CYC(2),
        .MAX_ANGLE(180), .MAX_STEP(0), .RESET_ANGLE(90)
    ) dut_a (
        .iClk(clk), .iRst(rst_a), .iAngle(angle_a), .iEn(en_a),
        .oPwm(pwm_a), .oFrame(frame_a), .oCurAngle(cur_a)
    );

    servo_pwm_gen #(
        .PERIOD_CYC(1000), .MIN_CYC(50), .STEP_CYC(2),
        .MAX_ANGLE(180), .MAX_STEP(30), .RESET_ANGLE(90)
    ) dut_b (
        .iClk(clk), .iRst(rst_b), .iAngle(angle_b), .iEn(en_b),
        .oPwm(pwm_b), .oFrame(frame_b), .oCurAngle(cur_b)
    );

    typedef struct {
        int w;
        int a;
    } exp_t;

    typedef struct {
        logic [7:0] angle;
        logic       en;
        int         delay;
        int         w;
        int         a;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t vecs[10];

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic timeout_fail(input string name);
        total++;
        $display("FAIL %s: timed out waiting for frame", name);
    endtask

    // Per-frame monitor for instance A.
    logic mon_en = 1'b0;
    logic active = 1'b0;
    int   per, high, ang;
    logic fell, glitch;
    int   frame_no = 0;

    always @(negedge clk) begin
        if (!mon_en) begin
            active = 1'b0;
        end else if (frame_a) begin
            if (active) begin
                frame_no++;
                if (q_a.size() == 0) begin
                    timeout_fail("scoreboard_underflow");
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check($sformatf("f%0d_width", frame_no), high, e.w);
                    check($sformatf("f%0d_angle", frame_no), ang, e.a);
                    check($sformatf("f%0d_period", frame_no), per, 1000);
                    check($sformatf("f%0d_glitch", frame_no), int'(glitch), 0);
                end
            end
            active = 1'b1;
            per    = 1;
            high   = pwm_a ? 1 : 0;
            fell   = !pwm_a;
            glitch = 1'b0;
            ang    = int'(cur_a);
        end else if (active) begin
            per++;
            if (pwm_a) begin
                if (fell) glitch = 1'b1;
                else high++;
            end else begin
                fell = 1'b1;
            end
        end
    end

    task automatic wait_frame_a(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_a && k < 2000);
        if (!frame_a) timeout_fail(name);
    endtask

    task automatic wait_frame_b(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_b && k < 2000);
        if (!frame_b) timeout_fail(name);
    endtask

    // Called at the negedge of a B frame's first cycle; returns at the next one.
    task automatic measure_b(output int w, output int p, output int a);
        w = pwm_b ? 1 : 0;
        p = 1;
        a = int'(cur_b);
        forever begin
            @(negedge clk);
            if (frame_b || p >= 2000) break;
            p++;
            if (pwm_b) w++;
        end
        if (!frame_b) timeout_fail("b_frame");
    endtask

    initial begin
        int w, p, a;
        exp_t e;

        vecs[0] = '{8'd0,   1'b1, 0,   50,  0};
        vecs[1] = '{8'd180, 1'b1, 0,   410, 180};
        vecs[2] = '{8'd200, 1'b1, 0,   410, 180};
        vecs[3] = '{8'd90,  1'b1, 0,   230, 90};
        vecs[4] = '{8'd90,  1'b1, 0,   230, 90};
        vecs[5] = '{8'd10,  1'b1, 100, 70,  10};
        vecs[6] = '{8'd90,  1'b1, 0,   230, 90};
        vecs[7] = '{8'd90,  1'b0, 20,  0,   90};
        vecs[8] = '{8'd90,  1'b1, 0,   230, 90};
        vecs[9] = '{8'd90,  1'b1, 0,   230, 90};

        rst_a = 1'b1; angle_a = 8'd90; en_a = 1'b1;
        rst_b = 1'b1; angle_b = 8'd90; en_b = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_pwm_a", int'(pwm_a), 0);
        check("rst_frame_a", int'(frame_a), 0);
        check("rst_cur_a", int'(cur_a), 90);
        check("rst_pwm_b", int'(pwm_b), 0);
        check("rst_frame_b", int'(frame_b), 0);
        check("rst_cur_b", int'(cur_b), 90);

        // First boundary is the first edge after release.
        q_a.push_back('{230, 90});
        mon_en = 1'b1;
        rst_a = 1'b0;
        @(negedge clk);
        check("first_frame", int'(frame_a), 1);
        check("first_pwm", int'(pwm_a), 1);

        for (int i = 0; i < 10; i++) begin
            if (i != 0) wait_frame_a($sformatf("vec%0d_wait", i));
            repeat (vecs[i].delay) @(negedge clk);
            angle_a = vecs[i].angle;
            en_a    = vecs[i].en;
            q_a.push_back('{vecs[i].w, vecs[i].a});
        end

        for (int k = 0; k < 3000 && q_a.size() != 0; k++) @(posedge clk);
        if (q_a.size() != 0) timeout_fail("drain_a");
        mon_en = 1'b0;

        // Reset mid-pulse, then restart with a new angle.
        wait_frame_a("pre_rst_wait");
        repeat (100) @(negedge clk);
        check("pwm_before_rst", int'(pwm_a), 1);
        rst_a = 1'b1;
        @(negedge clk);
        check("rst_mid_pwm", int'(pwm_a), 0);
        check("rst_mid_frame", int'(frame_a), 0);
        check("rst_mid_cur", int'(cur_a), 90);
        angle_a = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_hold_pwm", int'(pwm_a), 0);
        rst_a = 1'b0;
        @(negedge clk);
        check("rel_frame", int'(frame_a), 1);
        check("rel_pwm", int'(pwm_a), 1);
        check("rel_cur", int'(cur_a), 0);
        w = 1;
        p = 1;
        forever begin
            @(negedge clk);
            if (frame_a || p >= 2000) break;
            p++;
            if (pwm_a) w++;
        end
        check("rel_width", w, 50);
        check("rel_period", p, 1000);

        // Slew-limited instance: 90 -> 0 in 30-degree steps, then reverse.
        angle_b = 8'd0;
        q_b.push_back('{170, 60});
        q_b.push_back('{110, 30});
        q_b.push_back('{50, 0});
        rst_b = 1'b0;
        wait_frame_b("b_first");
        for (int i = 0; i < 5; i++) begin
            measure_b(w, p, a);
            if (i == 1) begin
                angle_b = 8'd180;
                q_b.push_back('{110, 30});
                q_b.push_back('{170, 60});
            end
            if (q_b.size() == 0) begin
                timeout_fail("b_underflow");
            end else begin
                e = q_b.pop_front();
                check($sformatf("b%0d_width", i), w, e.w);
                check($sformatf("b%0d_angle", i), a, e.a);
                check($sformatf("b%0d_period", i), p, 1000);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
